// File: rtl/vend_coin_arbiter.sv
// vend_coin_arbiter
// Front end for the vending core. Two coin slots share the core's single
// money_in port through a round-robin valid/ready arbiter. Each accepted coin
// is issued to the core as a one-cycle pulse. The core's goods_out/change
// result is then sampled, and any change is paid out through a hopper
// handshake, one 0.5 coin at a time. A hopper timeout locks the block out
// until reset.
//
// Ports
//   Clk, rst                       clock, async active-high reset
//   coin_{a,b}_valid/_val/_ready   slot handshakes (ready is combinational)
//   money_in                       registered coin pulse to the core
//   goods_out, change              result from the core
//   hop_req, hop_ack               hopper handshake, one 0.5 coin per ack
//   coin_rej                       pulse: accepted coin had an illegal code
//   vend_done                      pulse: vend and all change complete
//   busy                           high outside IDLE
//   hop_err                        sticky hopper timeout
module vend_coin_arbiter #(
  parameter int HOP_TIMEOUT = 16
) (
  input  logic       Clk,
  input  logic       rst,
  input  logic       coin_a_valid,
  input  logic [2:0] coin_a_val,
  output logic       coin_a_ready,
  input  logic       coin_b_valid,
  input  logic [2:0] coin_b_val,
  output logic       coin_b_ready,
  output logic [2:0] money_in,
  input  logic       goods_out,
  input  logic [1:0] change,
  output logic       hop_req,
  input  logic       hop_ack,
  output logic       coin_rej,
  output logic       vend_done,
  output logic       busy,
  output logic       hop_err
);

  localparam int TW = $clog2(HOP_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_PAYOUT, S_GAP} state_t;

  state_t        state, state_d;
  logic          last, last_d;          // 0 = slot A, 1 = slot B
  logic [1:0]    pay_cnt, pay_cnt_d;
  logic [TW-1:0] tmr, tmr_d;
  logic [2:0]    money_d;
  logic          hop_req_d, coin_rej_d, vend_done_d, hop_err_d, busy_d;

  logic          grant_a, grant_b, hs, legal;
  logic [2:0]    hs_val;

  // Round robin: on contention the slot that was not granted last wins.
  always_comb begin
    grant_a      = coin_a_valid & (~coin_b_valid | last);
    grant_b      = coin_b_valid & (~coin_a_valid | ~last);
    coin_a_ready = (state == S_IDLE) & ~hop_err & grant_a;
    coin_b_ready = (state == S_IDLE) & ~hop_err & grant_b;
    hs           = coin_a_ready | coin_b_ready;
    hs_val       = coin_a_ready ? coin_a_val : coin_b_val;
    case (hs_val)
      3'b001, 3'b010, 3'b100: legal = 1'b1;
      default:                legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state;
    last_d      = last;
    pay_cnt_d   = pay_cnt;
    tmr_d       = tmr;
    money_d     = 3'b000;
    hop_req_d   = 1'b0;
    coin_rej_d  = 1'b0;
    vend_done_d = 1'b0;
    hop_err_d   = hop_err;
    case (state)
      S_IDLE: begin
        if (hs) begin
          last_d = coin_b_ready;
          // The money_in register doubles as the coin latch, so the core
          // sees the coin in the cycle right after the handshake.
          if (legal) begin
            money_d = hs_val;
            state_d = S_ISSUE;
          end else begin
            coin_rej_d = 1'b1;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (!goods_out) begin
          state_d = S_IDLE;
        end else if (change == 2'b00) begin
          vend_done_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          pay_cnt_d = change;
          tmr_d     = '0;
          hop_req_d = 1'b1;
          state_d   = S_PAYOUT;
        end
      end
      S_PAYOUT: begin
        if (hop_ack) begin
          pay_cnt_d = pay_cnt - 2'd1;
          tmr_d     = '0;
          state_d   = S_GAP;
        end else if (tmr == TW'(HOP_TIMEOUT - 1)) begin
          // This was the last allowed unacknowledged cycle of hop_req.
          hop_err_d = 1'b1;
          pay_cnt_d = 2'd0;
          tmr_d     = '0;
          state_d   = S_IDLE;
        end else begin
          tmr_d     = tmr + 1'b1;
          hop_req_d = 1'b1;
        end
      end
      S_GAP: begin
        if (pay_cnt == 2'd0) begin
          vend_done_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          tmr_d     = '0;
          hop_req_d = 1'b1;
          state_d   = S_PAYOUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      last      <= 1'b1;
      pay_cnt   <= 2'd0;
      tmr       <= '0;
      money_in  <= 3'b000;
      hop_req   <= 1'b0;
      coin_rej  <= 1'b0;
      vend_done <= 1'b0;
      hop_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      last      <= last_d;
      pay_cnt   <= pay_cnt_d;
      tmr       <= tmr_d;
      money_in  <= money_d;
      hop_req   <= hop_req_d;
      coin_rej  <= coin_rej_d;
      vend_done <= vend_done_d;
      hop_err   <= hop_err_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: doc/vend_coin_arbiter.md
# vend_coin_arbiter

Front-end controller for the VENDING_MACHINE core. Shares its single `money_in` port between two coin acceptors (slot A, slot B) with round-robin arbitration and a valid/ready handshake, sequences one coin per transaction into the core, and samples the core's `goods_out`/`change` result. When change is due, it drives a coin-hopper handshake that pays out 0.5-unit coins one at a time, with a timeout and a sticky error lockout.

## Interface
- HOP_TIMEOUT, 16: cycles `hop_req` may stay high without `hop_ack` before an error is declared (≥2).
- Clk  in  1  clock, posedge active.
- rst  in  1  asynchronous, active-high reset. The core's `rst_n` is driven as `~rst` at top level.
- coin_a_valid  in  1  slot A holds a coin.
- coin_a_val  in  3  slot A coin code: 001 = 0.5, 010 = 1, 100 = 2.
- coin_a_ready  out  1  slot A coin accepted this cycle (valid & ready).
- coin_b_valid / coin_b_val / coin_b_ready: same as slot A, for slot B.
- money_in  out  3  to the core; registered, one-cycle coin pulse, otherwise 000.
- goods_out  in  1  from the core.
- change  in  2  from the core: 00 = 0, 01 = 0.5, 10 = 1, 11 = 1.5.
- hop_req  out  1  request one 0.5 coin from the hopper.
- hop_ack  in  1  hopper has dispensed one coin.
- coin_rej  out  1  one-cycle pulse: accepted coin had an illegal code and was discarded.
- vend_done  out  1  one-cycle pulse: vend and all change complete.
- busy  out  1  high in every state except IDLE.
- hop_err  out  1  sticky hopper-timeout error, cleared only by `rst`.

## Operation
- **States:** IDLE, ISSUE, WAIT, PAYOUT, GAP.
- **IDLE:**
  - The `ready` of the granted slot is high, combinationally, only while `hop_err` = 0.
  - Only one ready is ever high.
  - On handshake, latch the coin and go to ISSUE.
- **Arbitration:**
  - Pointer `last` holds the most recently granted slot; reset value is B, so A wins first.
  - Both valid: grant the slot that is not `last`.
  - One valid: grant that slot.
  - `last` updates on each handshake.
- **Illegal code** (anything other than 001/010/100):
  - Handshake completes normally.
  - `coin_rej` pulses the next cycle.
  - Stay in IDLE; the core sees no pulse.
- **ISSUE:** drive `money_in` = latched code for exactly one cycle, then go to WAIT.
- **WAIT:** sample `goods_out`/`change`.
  - `goods_out` = 0: go to IDLE, no `vend_done`.
  - `goods_out` = 1, `change` = 0: pulse `vend_done`, go to IDLE.
  - `goods_out` = 1, `change` ≠ 0: load the 2-bit `pay_cnt` with `change` (01→1, 10→2, 11→3 coins), go to PAYOUT.
- **PAYOUT:**
  - Hold `hop_req` = 1 and run the timeout counter.
  - On `hop_ack` = 1 (sampled at posedge): drop `hop_req`, decrement `pay_cnt`, go to GAP.
  - Counter reaches HOP_TIMEOUT with no ack: set `hop_err`, clear `pay_cnt`, drop `hop_req`, go to IDLE, no `vend_done`.
- **GAP:**
  - `hop_req` = 0 for exactly one cycle.
  - `pay_cnt` = 0: pulse `vend_done`, go to IDLE.
  - Otherwise return to PAYOUT; the timeout counter restarts at 0.
- **`hop_err` = 1:** both readies stay 0; the block stays in IDLE until `rst`.
- `hop_ack` outside PAYOUT is ignored.
- **Reset** (asynchronous, any state, including mid-payout):
  - State = IDLE, `last` = B, `pay_cnt` = 0, timeout counter = 0.
  - All outputs 0: `money_in` = 000, `hop_req`, `coin_rej`, `vend_done`, `hop_err`, `busy`.

## Timing
- Handshake at edge E0 (cycle T). `money_in` is valid during T+1 only. The core registers its result at the end of T+1. The block samples it in WAIT during T+2.
- No change due: the block is back in IDLE, with `ready` available, in T+3. `vend_done` (if any) is high during T+3.
- Change due: first `hop_req` is high in T+3.
  - Each coin takes ack-latency + 1 cycle in PAYOUT, plus 1 GAP cycle.
  - `vend_done` is high in the cycle after the final GAP.
- `coin_rej` is high in T+1; the next handshake is possible in T+1.
- Timeout: `hop_err` rises in the cycle after the HOP_TIMEOUT-th unacknowledged cycle of `hop_req`.
- `money_in`, `hop_req`, `coin_rej`, `vend_done`, `hop_err` and `busy` are registered outputs. The readies are combinational from state, `last`, the valids and `hop_err`.

## Test plan
- A sends 100 after reset → `money_in` = 100 in T+1 only. Core state is IDLE, so the core yields no goods. Block returns to IDLE in T+3, `vend_done` = 0.
- A sends 010, 010, then 100 (core holds 2 with the last coin; `goods_out` = 1, `change` = 11) → 3 `hop_req`/`hop_ack` cycles with one-cycle gaps, then a single `vend_done` pulse.
- A and B both valid every cycle → grants alternate A, B, A, B. With only B valid, B is granted repeatedly.
- Coin code 011 on A → `coin_a_ready` = 1, `coin_rej` pulse in T+1, `money_in` stays 000, no state change.
- Vend requiring 2 change coins, `hop_ack` never asserted with HOP_TIMEOUT = 16 → `hop_req` high for 16 cycles, then `hop_err` = 1 sticky, readies held 0, no `vend_done`.
- `rst` asserted during the second payout coin → all outputs 0 immediately. After release: IDLE, A has priority, `pay_cnt` = 0.
